// File: rtl/gpu_launch_ctrl_pkg.sv
// Shared constants for the GPU cluster: launch FSM encoding and the stack
// layout that the CPU reset SP values and the RAM memory map also derive from.
package gpu_launch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned SP_STRIDE_DEF = 256;
  localparam int unsigned A_OFS_DEF     = 20;
  localparam int unsigned B_OFS_DEF     = 24;

  // Address of an argument slot: ofs bytes below core's SP base (core+1)*stride.
  function automatic logic [31:0] arg_addr(input int unsigned core,
                                           input int unsigned stride,
                                           input int unsigned ofs);
    logic [31:0] base;
    base = 32'((core + 1) * stride);
    return base - 32'(ofs);
  endfunction

endpackage

// File: rtl/gpu_launch_ctrl_if.sv
// GPU RAM preload bus: one shared write enable, two write ports
// (port 0 carries argument A, port 1 carries argument B).
interface gpu_launch_ctrl_if
  import gpu_launch_ctrl_pkg::*;
  ;
  logic        WE;
  logic [31:0] ADDR_0;
  logic [31:0] DATA_0;
  logic [31:0] ADDR_1;
  logic [31:0] DATA_1;

  modport master (output WE, ADDR_0, DATA_0, ADDR_1, DATA_1);
  modport slave  (input  WE, ADDR_0, DATA_0, ADDR_1, DATA_1);
endinterface

// File: rtl/gpu_launch_ctrl_fin_tracker.sv
// Per-core finish tracker: IDLE must be high on two consecutive RUN cycles
// before the sticky FIN bit sets. fin_nxt is exported so the FSM can leave
// RUN on the same edge the last FIN bit sets.
module gpu_launch_ctrl_fin_tracker
  import gpu_launch_ctrl_pkg::*;
(
  input  logic CLK,
  input  logic RES_N,
  input  logic clr,
  input  logic en,
  input  logic idle,
  output logic fin_nxt,
  output logic fin
);

  logic idle_d;

  // Next FIN value: cleared on launch, otherwise set on a qualified IDLE.
  always_comb begin
    fin_nxt = clr ? 1'b0 : (fin | (en & idle & idle_d));
  end

  // IDLE history is only kept while RUN so settle-window activity never counts.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      idle_d <= 1'b0;
      fin    <= 1'b0;
    end else begin
      idle_d <= en & idle;
      fin    <= fin_nxt;
    end
  end

endmodule

// File: rtl/gpu_launch_ctrl.sv
// Launch sequencer for the GPU cluster: preloads per-core arguments into the
// stack frames, releases the cores, and waits for all of them to go idle.
//
//   state     | meaning
//   ST_IDLE   | cores held in reset, waiting for START
//   ST_LOAD   | one core's argument pair written per cycle
//   ST_SETTLE | cores released, IDLE ignored for SETTLE cycles
//   ST_RUN    | collecting FIN bits, timeout counter running
//   ST_DONE   | one-cycle DONE pulse, cores halted again
module gpu_launch_ctrl
  import gpu_launch_ctrl_pkg::*;
#(
  parameter int unsigned NCORES    = 4,
  parameter int unsigned SP_STRIDE = SP_STRIDE_DEF,
  parameter int unsigned A_OFS     = A_OFS_DEF,
  parameter int unsigned B_OFS     = B_OFS_DEF,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                  CLK,
  input  logic                  RES_N,
  input  logic                  START,
  input  logic [32*NCORES-1:0]  ARG_A,
  input  logic [32*NCORES-1:0]  ARG_B,
  input  logic [NCORES-1:0]     IDLE,
  gpu_launch_ctrl_if.master     ram,
  output logic                  CPU_RES,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [NCORES-1:0]     FIN
);

  localparam logic [2:0]  LAST_CORE = 3'(NCORES - 1);
  localparam logic [15:0] SETTLE_TC = 16'(SETTLE - 1);
  localparam logic [15:0] TMO_TC    = 16'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic [32*NCORES-1:0] arg_a, arg_b, arg_a_nxt, arg_b_nxt;
  logic                 err_q, err_nxt;
  logic                 start_acc;
  logic                 run_en;
  logic [NCORES-1:0]    fin_nxt, fin_q;

  logic        we_q, we_nxt;
  logic [31:0] addr_0_q, addr_0_nxt, data_0_q, data_0_nxt;
  logic [31:0] addr_1_q, addr_1_nxt, data_1_q, data_1_nxt;
  logic        cpu_res_q, cpu_res_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;

  assign run_en = (state == ST_RUN);

  for (genvar k = 0; k < int'(NCORES); k++) begin : g_fin
    gpu_launch_ctrl_fin_tracker u_fin (
      .CLK     (CLK),
      .RES_N   (RES_N),
      .clr     (start_acc),
      .en      (run_en),
      .idle    (IDLE[k]),
      .fin_nxt (fin_nxt[k]),
      .fin     (fin_q[k])
    );
  end

  // State, datapath and output registers; outputs load their next values so
  // every port is a flop that already reflects the state being entered.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      arg_a     <= '0;
      arg_b     <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_0_q  <= '0;
      data_0_q  <= '0;
      addr_1_q  <= '0;
      data_1_q  <= '0;
      cpu_res_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      arg_a     <= arg_a_nxt;
      arg_b     <= arg_b_nxt;
      err_q     <= err_nxt;
      we_q      <= we_nxt;
      addr_0_q  <= addr_0_nxt;
      data_0_q  <= data_0_nxt;
      addr_1_q  <= addr_1_nxt;
      data_1_q  <= data_1_nxt;
      cpu_res_q <= cpu_res_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  // Next-state logic, core index, settle/timeout counter and ERR.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    arg_a_nxt = arg_a;
    arg_b_nxt = arg_b;
    err_nxt   = err_q;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          arg_a_nxt = ARG_A;
          arg_b_nxt = ARG_B;
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (idx == LAST_CORE) begin
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_TC) begin
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_RUN: begin
        // Completion is checked first so a same-cycle timeout leaves ERR low.
        if (&fin_nxt) begin
          state_nxt = ST_DONE;
        end else if (cnt == TMO_TC) begin
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, registered above.
  always_comb begin
    we_nxt      = 1'b0;
    addr_0_nxt  = '0;
    data_0_nxt  = '0;
    addr_1_nxt  = '0;
    data_1_nxt  = '0;
    if (state_nxt == ST_LOAD) begin
      we_nxt     = 1'b1;
      addr_0_nxt = arg_addr({29'd0, idx_nxt}, SP_STRIDE, A_OFS);
      addr_1_nxt = arg_addr({29'd0, idx_nxt}, SP_STRIDE, B_OFS);
      data_0_nxt = arg_a_nxt[32*idx_nxt +: 32];
      data_1_nxt = arg_b_nxt[32*idx_nxt +: 32];
    end
    cpu_res_nxt = !((state_nxt == ST_SETTLE) || (state_nxt == ST_RUN));
    busy_nxt    = (state_nxt != ST_IDLE);
    done_nxt    = (state_nxt == ST_DONE);
  end

  assign ram.WE     = we_q;
  assign ram.ADDR_0 = addr_0_q;
  assign ram.DATA_0 = data_0_q;
  assign ram.ADDR_1 = addr_1_q;
  assign ram.DATA_1 = data_1_q;
  assign CPU_RES    = cpu_res_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign FIN        = fin_q;

endmodule
